// File: rtl/alu_exec.sv
// alu_exec: single-issue ALU execution stage with a valid/ready handshake on
// both sides. Logic and arithmetic codes finish one cycle after accept.
// Shifts walk a working register one bit per cycle, so a shift takes
// shamt+1 cycles to produce its result.

module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Cnt,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [SHW-1:0]   cnt_q;
  logic [SHW-1:0]   cnt_d;
  logic             ill_q;
  logic             ill_d;
  logic             left_q;
  logic             left_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             op_is_shift;
  logic             op_is_legal;
  logic [WIDTH-1:0] alu_val;

  assign accept = in_valid && in_ready;
  assign shamt  = src_b[SHW-1:0];

  // Decode the incoming code and compute the single-cycle result from the live
  // operands. This value is only stored on the accept edge, which is what
  // captures the operands.
  always_comb begin
    op_is_shift = 1'b0;
    op_is_legal = 1'b1;
    alu_val     = '0;
    case (ALU_Cnt)
      OP_AND: alu_val = src_a & src_b;
      OP_OR:  alu_val = src_a | src_b;
      OP_ADD: alu_val = src_a + src_b;
      OP_SUB: alu_val = src_a - src_b;
      OP_SLT: alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_NOR: alu_val = ~(src_a | src_b);
      OP_SLL, OP_SRL: begin
        op_is_shift = 1'b1;
        alu_val     = src_a;
      end
      default: begin
        op_is_legal = 1'b0;
        alu_val     = '0;
      end
    endcase
  end

  // Control FSM: next state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op_is_shift && (shamt != '0)) begin
            next_state = SHIFT;
          end else begin
            next_state = DONE;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_ONE) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath next values: capture on accept, step the shifter one bit per
  // cycle, and hold everything else so the result stays stable in DONE.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    ill_d  = ill_q;
    left_d = left_q;
    case (state)
      IDLE: begin
        if (accept) begin
          ill_d  = !op_is_legal;
          left_d = (ALU_Cnt == OP_SLL);
          if (op_is_shift && (shamt != '0)) begin
            work_d = src_a;
            cnt_d  = shamt;
          end else begin
            res_d = alu_val;
          end
        end
      end
      SHIFT: begin
        if (left_q) begin
          work_d = work_q << 1;
        end else begin
          work_d = work_q >> 1;
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d = work_d;
        end
      end
      default: begin
      end
    endcase
  end

  // State register; reset returns to IDLE and drops any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      ill_q  <= 1'b0;
      left_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      ill_q  <= ill_d;
      left_q <= left_d;
    end
  end

  assign result  = res_q;
  assign zero    = out_valid && (res_q == '0);
  assign illegal = out_valid && ill_q;

endmodule
